// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory port arbiter.
//   arb_state_e        : arbiter FSM state encoding
//   ARB_AW_DEF         : default address width
//   ARB_DW_DEF         : default data width
//   ARB_MAX_STREAK_DEF : default back-to-back data grant limit for the fetch starvation guard
package mem_arb_pkg;

  localparam int unsigned ARB_AW_DEF         = 32;
  localparam int unsigned ARB_DW_DEF         = 32;
  localparam int unsigned ARB_MAX_STREAK_DEF = 4;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_GRANT_IF = 2'd1,
    ARB_GRANT_D  = 2'd2,
    ARB_DONE     = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port and memory command/response signals.
//   slave  : arbiter view (takes port requests and memory responses, drives results/commands)
//   master : environment view (pipeline ports plus memory model)
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = ARB_AW_DEF,
  parameter int unsigned DW = ARB_DW_DEF
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;

  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_valid;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_valid,
    output if_rdata, if_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_valid,
    input  if_rdata, if_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/arb_streak_ctr.sv
// Saturating up-counter with synchronous clear; counts consecutive data grants
// made while fetch is waiting.
//   clk, reset : clock, async active-high reset
//   clr        : return count to zero (wins over inc)
//   inc        : increment, saturating at MAX_CNT
//   cnt        : registered count
module arb_streak_ctr #(
  parameter int unsigned MAX_CNT = 4,
  parameter int unsigned W       = $clog2(MAX_CNT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear has priority, increment stops at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != W'(MAX_CNT))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes instruction-fetch and data requests onto one single-port memory,
// one outstanding transaction at a time; data has priority over fetch.
// Optional macro ARB_STARVE_GUARD_EN: after MAX_STREAK data grants in a row
// with fetch waiting, the next grant goes to fetch.
//   clk, reset : clock, async active-high reset
//   bus        : fetch port, data port and memory command/response (slave modport)
//   busy       : high whenever the arbiter is not IDLE
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = ARB_AW_DEF,
  parameter int unsigned DW         = ARB_DW_DEF,
  parameter int unsigned MAX_STREAK = ARB_MAX_STREAK_DEF
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic                busy
);

  arb_state_e    state_q,    state_d;
  logic          m_req_q,    m_req_d;
  logic          m_we_q,     m_we_d;
  logic [AW-1:0] m_addr_q,   m_addr_d;
  logic [DW-1:0] m_wdata_q,  m_wdata_d;
  logic          if_ready_q, if_ready_d;
  logic          d_ready_q,  d_ready_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q,  d_rdata_d;
  logic          busy_q,     busy_d;

  logic          grant_if_c;
  logic          grant_d_c;
  logic          force_if_c;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);

  logic [STREAK_W-1:0] streak_cnt;
  logic                streak_inc_c;
  logic                streak_clr_c;

  // A data grant extends the streak only if fetch was left waiting.
  assign streak_inc_c = grant_d_c && bus.if_req;
  assign streak_clr_c = grant_if_c || (grant_d_c && !bus.if_req);
  assign force_if_c   = bus.if_req && (streak_cnt == STREAK_W'(MAX_STREAK));

  arb_streak_ctr #(
    .MAX_CNT (MAX_STREAK),
    .W       (STREAK_W)
  ) u_streak_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (streak_clr_c),
    .inc   (streak_inc_c),
    .cnt   (streak_cnt)
  );
`else
  assign force_if_c = 1'b0;

  // Strict priority build: the streak limit has no hardware behind it.
  if (MAX_STREAK == 0) begin : g_zero_streak
  end
`endif

  // Next-state and registered command/response datapath.
  always_comb begin
    state_d    = state_q;
    m_req_d    = 1'b0;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant_if_c = 1'b0;
    grant_d_c  = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (bus.d_req && !force_if_c) begin
          state_d   = ARB_GRANT_D;
          m_req_d   = 1'b1;
          m_we_d    = bus.d_we;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
          grant_d_c = 1'b1;
        end else if (bus.if_req) begin
          state_d    = ARB_GRANT_IF;
          m_req_d    = 1'b1;
          m_we_d     = 1'b0;
          m_addr_d   = bus.if_addr;
          grant_if_c = 1'b1;
        end
      end
      ARB_GRANT_IF: begin
        if (bus.m_valid) begin
          state_d    = ARB_DONE;
          if_rdata_d = bus.m_rdata;
          if_ready_d = 1'b1;
        end
      end
      ARB_GRANT_D: begin
        if (bus.m_valid) begin
          state_d   = ARB_DONE;
          d_rdata_d = bus.m_rdata;
          d_ready_d = 1'b1;
        end
      end
      ARB_DONE: begin
        // Requests here wait for IDLE so the ready pulse stays one cycle.
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.m_req    = m_req_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.if_ready = if_ready_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_ready  = d_ready_q;
  assign bus.d_rdata  = d_rdata_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset values, fetch read, data write,
// simultaneous requests, continuous contention and reset abort.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  int n_cmp = 0;
  int n_err = 0;
  int if_rdy_cnt = 0;
  int d_rdy_cnt  = 0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW         (AW),
    .DW         (DW),
    .MAX_STREAK (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Ready pulses counted mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus.if_ready === 1'b1) if_rdy_cnt++;
    if (bus.d_ready === 1'b1) d_rdy_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mreq(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.m_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Both ports request continuously; memory answers one cycle after each m_req.
  task automatic run_stream(input int n, input bit guard);
    bit ok;
    logic [AW-1:0] exp_addr;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0000_0080;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0090;
    for (int k = 0; k < n; k++) begin
      wait_mreq(20, ok);
      if (!ok) begin
        check($sformatf("grant%0d_timeout", k), 64'd0, 64'd1);
        break;
      end
      exp_addr = (guard && ((k % 5) == 4)) ? 32'h0000_0090 : 32'h0000_0080;
      check($sformatf("grant%0d_addr", k), 64'(bus.m_addr), 64'(exp_addr));
      step();
      bus.m_valid = 1'b1;
      bus.m_rdata = DW'(k);
      step();
      bus.m_valid = 1'b0;
    end
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    step();
    step();
    check("stream_end_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int d_base;
    int if_base;

    reset       = 1'b1;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.m_rdata = '0;
    bus.m_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset values
    check("rst_m_req",    64'(bus.m_req),    64'd0);
    check("rst_m_we",     64'(bus.m_we),     64'd0);
    check("rst_m_addr",   64'(bus.m_addr),   64'd0);
    check("rst_m_wdata",  64'(bus.m_wdata),  64'd0);
    check("rst_if_ready", 64'(bus.if_ready), 64'd0);
    check("rst_d_ready",  64'(bus.d_ready),  64'd0);
    check("rst_if_rdata", 64'(bus.if_rdata), 64'd0);
    check("rst_d_rdata",  64'(bus.d_rdata),  64'd0);
    check("rst_busy",     64'(busy),         64'd0);

    // Fetch read, memory answers two cycles after m_req
    if_base     = if_rdy_cnt;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0010;
    step();
    check("if_m_req",  64'(bus.m_req),  64'd1);
    check("if_m_addr", 64'(bus.m_addr), 64'h10);
    check("if_m_we",   64'(bus.m_we),   64'd0);
    check("if_busy",   64'(busy),       64'd1);
    step();
    check("if_m_req_one_cycle", 64'(bus.m_req), 64'd0);
    check("if_ready_early",     64'(bus.if_ready), 64'd0);
    step();
    bus.m_valid = 1'b1;
    bus.m_rdata = 32'h0051_3093;
    step();
    check("if_ready",  64'(bus.if_ready), 64'd1);
    check("if_rdata",  64'(bus.if_rdata), 64'h0051_3093);
    check("if_d_ready_quiet", 64'(bus.d_ready), 64'd0);
    bus.m_valid = 1'b0;
    bus.if_req  = 1'b0;
    step();
    check("if_ready_drop",  64'(bus.if_ready), 64'd0);
    check("if_busy_done",   64'(busy),         64'd0);
    check("if_rdata_hold",  64'(bus.if_rdata), 64'h0051_3093);
    check("if_ready_pulses", 64'(if_rdy_cnt - if_base), 64'd1);

    // Data write, memory answers one cycle after m_req
    d_base      = d_rdy_cnt;
    if_base     = if_rdy_cnt;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h0000_0064;
    bus.d_wdata = 32'hDEAD_BEEF;
    step();
    check("wr_m_req",   64'(bus.m_req),   64'd1);
    check("wr_m_we",    64'(bus.m_we),    64'd1);
    check("wr_m_addr",  64'(bus.m_addr),  64'h64);
    check("wr_m_wdata", 64'(bus.m_wdata), 64'hDEAD_BEEF);
    step();
    bus.m_valid = 1'b1;
    bus.m_rdata = 32'h0BAD_F00D;
    step();
    check("wr_d_ready", 64'(bus.d_ready), 64'd1);
    bus.m_valid = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    step();
    check("wr_busy_done",     64'(busy),                    64'd0);
    check("wr_d_ready_pulses", 64'(d_rdy_cnt - d_base),     64'd1);
    check("wr_if_ready_quiet", 64'(if_rdy_cnt - if_base),   64'd0);

    // Simultaneous requests: data first, fetch after data drops
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0020;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0000_0040;
    step();
    check("sim_first_addr", 64'(bus.m_addr), 64'h40);
    check("sim_first_req",  64'(bus.m_req),  64'd1);
    step();
    bus.m_valid = 1'b1;
    bus.m_rdata = 32'hA5A5_0001;
    step();
    check("sim_d_ready",      64'(bus.d_ready),  64'd1);
    check("sim_d_rdata",      64'(bus.d_rdata),  64'hA5A5_0001);
    check("sim_if_not_ready", 64'(bus.if_ready), 64'd0);
    bus.m_valid = 1'b0;
    bus.d_req   = 1'b0;
    step();
    check("sim_done_no_req", 64'(bus.m_req), 64'd0);
    step();
    check("sim_second_req",  64'(bus.m_req),  64'd1);
    check("sim_second_addr", 64'(bus.m_addr), 64'h20);
    step();
    bus.m_valid = 1'b1;
    bus.m_rdata = 32'h1111_2222;
    step();
    check("sim_if_ready", 64'(bus.if_ready), 64'd1);
    check("sim_if_rdata", 64'(bus.if_rdata), 64'h1111_2222);
    bus.m_valid = 1'b0;
    bus.if_req  = 1'b0;
    step();
    step();

    // Continuous contention
`ifdef ARB_STARVE_GUARD_EN
    run_stream(12, 1'b1);
`else
    run_stream(7, 1'b0);
`endif

    // Reset two cycles after m_req aborts a data read
    d_base     = d_rdy_cnt;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h0000_00C0;
    step();
    check("abort_m_req", 64'(bus.m_req), 64'd1);
    step();
    step();
    reset = 1'b1;
    #1;
    check("abort_busy_async",  64'(busy),        64'd0);
    check("abort_d_rdata_clr", 64'(bus.d_rdata), 64'd0);
    step();
    reset     = 1'b0;
    bus.d_req = 1'b0;
    bus.m_valid = 1'b1;
    bus.m_rdata = 32'hFFFF_0000;
    step();
    bus.m_valid = 1'b0;
    check("abort_late_valid_busy", 64'(busy), 64'd0);
    step();
    check("abort_no_d_ready", 64'(d_rdy_cnt - d_base), 64'd0);
    check("abort_m_req_idle", 64'(bus.m_req),          64'd0);
    check("abort_d_rdata",    64'(bus.d_rdata),        64'd0);
    check("abort_busy",       64'(busy),               64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port unified memory between the pipeline's instruction-fetch port and its data port. It sits between the RISC-V pipeline core and the memory. Each port issues requests with a req/ready handshake. The arbiter serializes them into one outstanding memory transaction at a time and returns read data to the winning port. Data accesses have priority. An optional streak limit stops fetch from starving.

## Interface
- `AW`, default 32: address width (byte address, word-aligned).
- `DW`, default 32: data width.
- `MAX_STREAK`, default 4: number of back-to-back data grants allowed while fetch waits (used only with the guard enabled).
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held high with `if_addr` stable until `if_ready`.
- `if_addr`  in  AW  fetch address.
- `if_rdata`  out  DW  fetch read data, valid while `if_ready`=1.
- `if_ready`  out  1  one-cycle completion pulse for fetch.
- `d_req`  in  1  data request; `d_we`, `d_addr`, `d_wdata` held stable until `d_ready`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  AW  data address.
- `d_wdata`  in  DW  write data.
- `d_rdata`  out  DW  data read data, valid while `d_ready`=1 and `d_we`=0.
- `d_ready`  out  1  one-cycle completion pulse for data (reads and writes).
- `m_req`  out  1  one-cycle memory command strobe.
- `m_we`, `m_addr`, `m_wdata`  out  1/AW/DW  memory command, registered, held from the `m_req` cycle until completion.
- `m_rdata`  in  DW  memory read data, valid with `m_valid`.
- `m_valid`  in  1  memory completion, at least 1 cycle after `m_req`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, GRANT_IF, GRANT_D, DONE.
- **IDLE:**
  - If `d_req` is high (and the guard is not forcing fetch), the arbiter latches the data command and goes to GRANT_D.
  - Otherwise, if `if_req` is high, it latches `if_addr` with `m_we`=0 and goes to GRANT_IF.
  - With neither request, it stays in IDLE.
- `m_req` is asserted for exactly the first cycle of GRANT_IF or GRANT_D.
- **GRANT_x:** waits for `m_valid`. On `m_valid`, it registers `m_rdata` into `x_rdata`, sets `x_ready`=1, and goes to DONE.
- **DONE:** lasts one cycle with `x_ready` high, then goes to IDLE.
  - Requests seen during DONE are ignored.
  - A requester may keep `req` high for its next transaction; that request is arbitrated in IDLE.
- `m_valid` received in IDLE or DONE is ignored.
- `if_rdata` and `d_rdata` hold their last value until overwritten. They are 0 after reset.
- Reset values:
  - State = IDLE.
  - `m_req`, `m_we`, `if_ready`, `d_ready`, `busy` = 0.
  - `m_addr`, `m_wdata`, `if_rdata`, `d_rdata` = 0.
  - Streak counter = 0.
- Reset asserted mid-transaction aborts the transaction. No ready pulse is produced. A late `m_valid` after reset is ignored.

## Timing
- Grant latency: a request seen in IDLE at edge N gives `m_req`=1 in cycle N+1.
- Completion: `m_valid` sampled at edge M gives `x_ready`=1 in cycle M+1, then IDLE at M+2.
- Minimum transaction length, request to ready: 3 cycles when `m_valid` arrives one cycle after `m_req`.
- Only one memory transaction is outstanding at any time.
- Simultaneous `if_req` and `d_req` in IDLE: data wins unless the streak guard fires.

## Configuration
- Macro: `ARB_STARVE_GUARD_EN`.
- **Defined:**
  - A streak counter, `$clog2(MAX_STREAK+1)` bits wide, increments on each data grant made while `if_req`=1.
  - It resets to 0 on every fetch grant, and on any grant made while `if_req`=0.
  - When the counter equals `MAX_STREAK` and `if_req`=1 in IDLE, fetch is granted even if `d_req`=1.
- **Undefined:** strict data priority. No counter logic is synthesized, and fetch may starve indefinitely.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the FSM state enum (`ARB_IDLE`, `ARB_GRANT_IF`, `ARB_GRANT_D`, `ARB_DONE`);
  - the default widths;
  - the default `MAX_STREAK`.
- Sub-module `arb_streak_ctr` (saturating counter with clear) is instantiated only under `ARB_STARVE_GUARD_EN`.
- Everything else is a single always block FSM plus a registered command/response datapath.

## Test plan
- **Reset during GRANT_D:** assert `reset` two cycles after `m_req`, then deliver `m_valid`. Required: no `d_ready`, `busy`=0, `m_req` stays 0 until a new request.
- **Fetch read:** `if_req`=1, `if_addr`=0x0000_0010; memory returns 0x0051_3093 two cycles after `m_req`. Required: `m_addr`=0x10, `m_we`=0, `if_rdata`=0x0051_3093 with `if_ready` pulsed exactly one cycle.
- **Data write:** `d_req`=1, `d_we`=1, `d_addr`=0x64, `d_wdata`=0xDEAD_BEEF. Required: `m_we`=1, `m_addr`=0x64, `m_wdata`=0xDEAD_BEEF, one `d_ready` pulse, `if_ready` stays 0.
- **Simultaneous requests, guard off:** `if_req`=`d_req`=1. Required: data is served first; fetch is served in the following transaction once `d_req` drops.
- **Starvation guard on, `MAX_STREAK`=4:** hold `d_req` and `if_req` high continuously. Required: grant order D,D,D,D,IF,D, repeating.
